vec_mem_stage: RTL and testbench

- Memory-stage consumer of the EX/MEM pipeline register outputs.
- Executes scalar and unit-stride 16-lane vector loads and stores against a single-port, 32-bit, synchronous data RAM with 1-cycle read latency.
- Serializes a vector access into one RAM access per lane, holds the pipeline with StallM until done, and assembles load results into a 16x32 read-data vector for the MEM/WB register.

---
 rtl/vmem_pkg.sv | 16 +
 rtl/vmem_rd_collect.sv | 40 ++++
 rtl/vec_mem_stage.sv | 158 +++++++++++++++
 tb/tb_vec_mem_stage.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vmem_pkg.sv
// vmem_pkg: shared types for the vector memory stage.
//   LANES / DATA_W : vector geometry (16 x 32-bit)
//   LANE_W         : lane index width
//   vec_t          : 16x32 packed lane vector
//   vmem_state_t   : memory-stage FSM states
//   vmem_op_t      : latched access kind
package vmem_pkg;
  localparam int LANES  = 16;
  localparam int DATA_W = 32;
  localparam int LANE_W = $clog2(LANES);

  typedef logic [LANES-1:0][DATA_W-1:0] vec_t;

  typedef enum logic [1:0] {IDLE, ACCESS, DRAIN, DONE} vmem_state_t;
  typedef enum logic       {OP_LOAD, OP_STORE}          vmem_op_t;
endpackage

// File: rtl/vmem_rd_collect.sv
// vmem_rd_collect: load assembly buffer for the vector memory stage.
// The RAM returns data one cycle after the read is issued, so the lane
// index and read enable are delayed one cycle and used to steer mem_rdata
// into the matching 32-bit slot.
//   CLK, RST_N : clock, synchronous active-low reset
//   clr        : zero the whole buffer (start of a new load)
//   issueEn    : a RAM read is issued this cycle
//   issueLane  : lane of the read issued this cycle
//   rdata      : RAM read data (belongs to last cycle's read)
//   rdVec      : assembled 16x32 load vector (registered)
module vmem_rd_collect
  import vmem_pkg::*;
(
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              clr,
  input  logic              issueEn,
  input  logic [LANE_W-1:0] issueLane,
  input  logic [DATA_W-1:0] rdata,
  output vec_t              rdVec
);

  logic              capEn;
  logic [LANE_W-1:0] capLane;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      capEn   <= 1'b0;
      capLane <= '0;
      rdVec   <= '0;
    end else begin
      capEn   <= issueEn;
      capLane <= issueLane;
      // clr and capEn never coincide (clr only leaves IDLE), clr wins anyway
      if (clr)        rdVec          <= '0;
      else if (capEn) rdVec[capLane] <= rdata;
    end
  end

endmodule

// File: rtl/vec_mem_stage.sv
// vec_mem_stage: memory stage for scalar and unit-stride 16-lane vector
// loads/stores on a single-port 32-bit synchronous RAM (1-cycle read).
// A vector access is serialized into one RAM access per lane while StallM
// freezes the front of the pipeline; DoneM pulses when the access retires.
// Optional feature: define VMEM_BOUNDS_CHK_EN to fault vector accesses
// whose last lane would pass the top of RAM (no RAM traffic, MemFaultM
// pulses with DoneM). Undefined: addresses wrap and MemFaultM is 0.
// Ports:
//   CLK, RST_N            : clock, synchronous active-low reset
//   ALUResultM            : lane 0 [ADDR_W-1:0] = base word address
//   WriteDataM            : store data, lane i -> base+i
//   MemtoRegM, MemWriteM  : load / store request (store wins if both)
//   v_s_m                 : 1 = vector (16 lanes), 0 = scalar (lane 0)
//   mem_addr/wdata/we/re  : RAM request
//   mem_rdata             : RAM read data, valid the cycle after mem_re
//   ReadDataM             : assembled load data, held until next load
//   StallM, DoneM         : pipeline freeze, completion pulse
//   MemFaultM             : bounds fault pulse
module vec_mem_stage
  import vmem_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int LANES  = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  vec_t              ALUResultM,
  input  vec_t              WriteDataM,
  input  logic              MemtoRegM,
  input  logic              MemWriteM,
  input  logic              v_s_m,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output vec_t              ReadDataM,
  output logic              StallM,
  output logic              DoneM,
  output logic              MemFaultM
);

  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

  vmem_state_t       stateQ, stateNxt;
  vmem_op_t          opQ;
  logic [LANE_W-1:0] laneQ, countQ;
  logic [ADDR_W-1:0] baseQ;
  vec_t              dataQ;
  logic              req, faultReq, accept, clrBuf;

  assign req = MemtoRegM | MemWriteM;

  // Only lane 0's low address bits matter.
  logic unusedAluBits;
  assign unusedAluBits = ^{ALUResultM[LANES-1:1], ALUResultM[0][DATA_W-1:ADDR_W]};

`ifdef VMEM_BOUNDS_CHK_EN
  localparam logic [ADDR_W:0] LAST_OFS = (ADDR_W+1)'(LANES - 1);
  logic [ADDR_W:0] endAddr;
  logic            faultQ;

  // Carry out of base+15 means the last lane falls off the top of RAM.
  assign endAddr   = {1'b0, ALUResultM[0][ADDR_W-1:0]} + LAST_OFS;
  assign faultReq  = req & v_s_m & endAddr[ADDR_W];
  assign MemFaultM = (stateQ == DONE) & faultQ;

  always_ff @(posedge CLK) begin
    if (!RST_N)              faultQ <= 1'b0;
    else if (stateQ == IDLE) faultQ <= faultReq;
  end
`else
  assign faultReq  = 1'b0;
  assign MemFaultM = 1'b0;
`endif

  always_comb begin
    stateNxt = stateQ;
    StallM   = 1'b0;
    DoneM    = 1'b0;
    mem_we   = 1'b0;
    mem_re   = 1'b0;
    accept   = 1'b0;
    clrBuf   = 1'b0;
    case (stateQ)
      IDLE: begin
        if (req) begin
          StallM = 1'b1;
          if (faultReq) begin
            stateNxt = DONE;
          end else begin
            stateNxt = ACCESS;
            accept   = 1'b1;
            clrBuf   = ~MemWriteM;
          end
        end
      end
      ACCESS: begin
        StallM = 1'b1;
        if (opQ == OP_STORE) mem_we = 1'b1;
        else                 mem_re = 1'b1;
        // loads need one extra cycle to catch the last lane's read data
        if (laneQ == countQ) stateNxt = (opQ == OP_STORE) ? DONE : DRAIN;
      end
      DRAIN: begin
        StallM   = 1'b1;
        stateNxt = DONE;
      end
      DONE: begin
        // EM still shows the retiring instruction here; requests ignored
        DoneM    = 1'b1;
        stateNxt = IDLE;
      end
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      stateQ <= IDLE;
      laneQ  <= '0;
      countQ <= '0;
      opQ    <= OP_LOAD;
    end else begin
      stateQ <= stateNxt;
      if (accept) begin
        laneQ  <= '0;
        countQ <= v_s_m ? LAST_LANE : '0;
        opQ    <= MemWriteM ? OP_STORE : OP_LOAD;
      end else if (stateQ == ACCESS && laneQ != countQ) begin
        laneQ  <= laneQ + LANE_W'(1);
      end
    end
  end

  // Operand latch; only meaningful after accept, so no reset needed.
  always_ff @(posedge CLK) begin
    if (accept) begin
      baseQ <= ALUResultM[0][ADDR_W-1:0];
      dataQ <= WriteDataM;
    end
  end

  // Wrap modulo 2^ADDR_W falls out of the fixed-width add.
  assign mem_addr  = baseQ + {{(ADDR_W-LANE_W){1'b0}}, laneQ};
  assign mem_wdata = dataQ[laneQ];

  vmem_rd_collect uCollect (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .clr       (clrBuf),
    .issueEn   (mem_re),
    .issueLane (laneQ),
    .rdata     (mem_rdata),
    .rdVec     (ReadDataM)
  );

endmodule

// File: tb/tb_vec_mem_stage.sv
// tb_vec_mem_stage: randomized self-checking bench for vec_mem_stage.
// A plain RAM array stands in for the data RAM; a transaction-level model
// (shadow memory + expected load vector + per-cycle timing from the access
// latencies) drives the expectations that one negedge process compares.
module tb_vec_mem_stage;
  import vmem_pkg::*;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              CLK = 1'b0;
  logic              RST_N;
  vec_t              ALUResultM, WriteDataM;
  logic              MemtoRegM, MemWriteM, v_s_m;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata, mem_rdata;
  logic              mem_we, mem_re;
  vec_t              ReadDataM;
  logic              StallM, DoneM, MemFaultM;

  always #5 CLK = ~CLK;

  vec_mem_stage #(.ADDR_W(ADDR_W), .LANES(16)) dut (
    .CLK(CLK), .RST_N(RST_N), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM), .v_s_m(v_s_m),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .ReadDataM(ReadDataM), .StallM(StallM), .DoneM(DoneM),
    .MemFaultM(MemFaultM)
  );

  // RAM environment
  logic [31:0] ram [DEPTH];
  logic        ramClr;
  always @(posedge CLK) begin
    if (ramClr) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= '0;
    end else begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      if (mem_re) mem_rdata <= ram[mem_addr];
    end
  end

  // model state
  logic [31:0] refMem [DEPTH];
  vec_t        refRd;
  int          tests = 0, fails = 0, reCnt = 0;

  logic              chkEn, expStall, expWe, expRe, expDone, expFault, chkRd;
  logic [ADDR_W-1:0] expAddr;
  logic [31:0]       expWdata;
  vec_t              expRd;

  task automatic chk1(input string nm, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0b expected %0b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chkV(input string nm, input vec_t act, input vec_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // single compare process
  always @(negedge CLK) begin
    if (chkEn) begin
      chk1("StallM", StallM, expStall);
      chk1("mem_we", mem_we, expWe);
      chk1("mem_re", mem_re, expRe);
      chk1("DoneM", DoneM, expDone);
      chk1("MemFaultM", MemFaultM, expFault);
      chk1("we_re_exclusive", mem_we & mem_re, 1'b0);
      if (expWe || expRe) chk32("mem_addr", 32'(mem_addr), 32'(expAddr));
      if (expWe)          chk32("mem_wdata", mem_wdata, expWdata);
      if (chkRd)          chkV("ReadDataM", ReadDataM, expRd);
      if (mem_re) reCnt++;
    end
  end

  task automatic setIdle();
    MemtoRegM = 1'b0; MemWriteM = 1'b0; v_s_m = 1'b0;
    expStall = 1'b0; expWe = 1'b0; expRe = 1'b0; expDone = 1'b0; expFault = 1'b0;
    chkRd = 1'b1; expRd = refRd;
  endtask

  function automatic vec_t randVec();
    vec_t v;
    for (int i = 0; i < 16; i++) v[i] = $urandom;
    return v;
  endfunction

  // One instruction held in EM from its request cycle through DoneM.
  // abortAt >= 0: assert reset during cycle abortAt instead of finishing.
  task automatic runOp(input logic st, input logic ld, input logic vec,
                       input logic [ADDR_W-1:0] base, input vec_t wd, input int abortAt);
    int   n, lat, last;
    logic flt;
    vec_t newRd;
    n   = vec ? 16 : 1;
    flt = 1'b0;
`ifdef VMEM_BOUNDS_CHK_EN
    flt = vec && (int'(base) + 15 > DEPTH - 1);
`endif
    lat   = flt ? 1 : (st ? n + 1 : n + 2);
    last  = (abortAt >= 0) ? abortAt : lat;
    newRd = refRd;
    if (!flt) begin
      if (st) begin
        for (int i = 0; i < n; i++)
          if (abortAt < 0 || i + 1 <= abortAt) refMem[(int'(base) + i) % DEPTH] = wd[i];
      end else begin
        newRd = '0;
        for (int i = 0; i < n; i++) newRd[i] = refMem[(int'(base) + i) % DEPTH];
      end
    end
    @(posedge CLK); #1;
    ALUResultM = randVec();
    ALUResultM[0][ADDR_W-1:0] = base;
    WriteDataM = wd;
    MemWriteM  = st; MemtoRegM = ld; v_s_m = vec;
    for (int k = 0; k <= last; k++) begin
      if (k > 0) begin @(posedge CLK); #1; end
      expStall = (k < lat);
      expDone  = (k == lat);
      expFault = flt && (k == lat);
      expWe    = !flt && st  && k >= 1 && k <= n;
      expRe    = !flt && !st && k >= 1 && k <= n;
      if (k >= 1 && k <= n) begin
        expAddr  = ADDR_W'((int'(base) + k - 1) % DEPTH);
        expWdata = wd[k-1];
      end
      chkRd = (k == 0) || (k == lat) || st || flt;
      expRd = (k == lat) ? newRd : refRd;
    end
    if (abortAt >= 0) begin
      RST_N = 1'b0;
      MemWriteM = 1'b0; MemtoRegM = 1'b0; v_s_m = 1'b0;
      refRd = '0;
      @(posedge CLK); #1;
      RST_N = 1'b1;
      setIdle();
    end else begin
      refRd = newRd;
      @(posedge CLK); #1;
      setIdle();
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge CLK); #1; setIdle(); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t wd;
    int   bad;
    chkEn = 1'b0; RST_N = 1'b0; ramClr = 1'b1;
    ALUResultM = '0; WriteDataM = '0;
    for (int i = 0; i < DEPTH; i++) refMem[i] = '0;
    refRd = '0;
    setIdle();
    repeat (2) @(posedge CLK);
    #1;
    ramClr = 1'b0;
    chkEn  = 1'b1;          // checks reset state while RST_N still low
    @(posedge CLK); #1;
    RST_N = 1'b1;
    idle(1);

    // vector store 0x3F0..0x3FF
    for (int i = 0; i < 16; i++) wd[i] = 32'hA000_0000 + i;
    runOp(1'b1, 1'b0, 1'b1, 10'h3F0, wd, -1);
    chk32("vst_ram_3F0", ram[10'h3F0], 32'hA000_0000);
    chk32("vst_ram_3FF", ram[10'h3FF], 32'hA000_000F);

    // vector load of the same region
    reCnt = 0;
    runOp(1'b0, 1'b1, 1'b1, 10'h3F0, randVec(), -1);
    chk32("vld_lane0", ReadDataM[0], 32'hA000_0000);
    chk32("vld_lane15", ReadDataM[15], 32'hA000_000F);
    chk32("vld_re_cycles", 32'(reCnt), 32'd16);

    // scalar store then scalar load at 0x005
    wd = '0; wd[0] = 32'hDEADBEEF;
    runOp(1'b1, 1'b0, 1'b0, 10'h005, wd, -1);
    idle(2);
    runOp(1'b0, 1'b1, 1'b0, 10'h005, randVec(), -1);
    chk32("sld_lane0", ReadDataM[0], 32'hDEADBEEF);
    chk32("sld_lane1", ReadDataM[1], 32'h0);
    chk32("sld_lane15", ReadDataM[15], 32'h0);

    // load and store both requested: store wins
    reCnt = 0;
    wd = randVec(); wd[0] = 32'h1234_5678;
    runOp(1'b1, 1'b1, 1'b0, 10'h020, wd, -1);
    chk32("both_no_re", 32'(reCnt), 32'd0);
    chk32("both_ram", ram[10'h020], 32'h1234_5678);
    chk32("both_rd_kept", ReadDataM[0], 32'hDEADBEEF);

    // vector store crossing the top of RAM
    wd = randVec();
    runOp(1'b1, 1'b0, 1'b1, 10'h3FA, wd, -1);
`ifdef VMEM_BOUNDS_CHK_EN
    chk32("flt_ram_009", ram[10'h009], 32'h0);
    chk32("flt_ram_3FA", ram[10'h3FA], 32'hA000_000A);
`else
    chk32("wrap_ram_3FA", ram[10'h3FA], wd[0]);
    chk32("wrap_ram_009", ram[10'h009], wd[15]);
`endif

    // reset during lane 7 of a vector store
    idle(1);
    wd = randVec();
    runOp(1'b1, 1'b0, 1'b1, 10'h100, wd, 8);
    chk32("rst_ram_lane0", ram[10'h100], wd[0]);
    chk32("rst_ram_lane6", ram[10'h106], wd[6]);
    chk32("rst_ram_lane8", ram[10'h108], 32'h0);
    idle(2);

    // randomized traffic
    for (int t = 0; t < 60; t++) begin
      logic st, ld, vec;
      st  = ($urandom_range(0, 1) == 1);
      ld  = st ? ($urandom_range(0, 3) == 0) : 1'b1;
      vec = ($urandom_range(0, 2) != 0);
      runOp(st, ld, vec, ADDR_W'($urandom_range(0, DEPTH - 1)), randVec(), -1);
      idle($urandom_range(0, 2));
    end

    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (ram[i] !== refMem[i]) bad++;
    chk32("ram_image_mismatches", 32'(bad), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
